// File: rtl/sts_ctrl_pkg.sv
// Shared types and default constants for the status snapshot sequencer.
package sts_ctrl_pkg;

  // Sequencer states: wait for request, let the live bus settle, freeze it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int DEF_TOTAL_WIDTH   = 160;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_PERIOD_WIDTH  = 32;
  localparam int DEF_SEQ_WIDTH     = 16;

  // Width of the settle down-counter; at least one bit even when unused.
  function automatic int settle_cnt_w(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/sts_period_timer.sv
// Auto-snapshot period timer: counts 0..auto_period-1 and ticks on the
// terminal count. A period of 0 parks the counter; any period change
// restarts counting from 0 without ticking.
module sts_period_timer
  import sts_ctrl_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [PERIOD_WIDTH-1:0] auto_period,
  output logic                    tick
);

  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    chg;
  logic                    term;

  assign chg  = (auto_period != period_q);
  assign term = (period_q != '0) && (cnt == period_q - PERIOD_WIDTH'(1));
  // The cycle that observes a new period never ticks; counting restarts.
  assign tick = !chg && term;

  // Period register and free-running counter with restart on change.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt      <= '0;
      period_q <= auto_period;
    end else if (chg) begin
      cnt      <= '0;
      period_q <= auto_period;
    end else if (term || (period_q == '0)) begin
      cnt      <= '0;
    end else begin
      cnt      <= cnt + PERIOD_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sts_snapshot_ctrl.sv
// Status snapshot sequencer: freezes a coherent copy of the live status
// bus on a manual (toggle) or periodic request, after a settle delay,
// and optionally pulses the abs-max tracker clear with each capture.
module sts_snapshot_ctrl
  import sts_ctrl_pkg::*;
#(
  parameter int TOTAL_WIDTH   = DEF_TOTAL_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int PERIOD_WIDTH  = DEF_PERIOD_WIDTH,
  parameter int SEQ_WIDTH     = DEF_SEQ_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [TOTAL_WIDTH-1:0]  live_sts,
  input  logic                    snap_toggle,
  input  logic [PERIOD_WIDTH-1:0] auto_period,
  input  logic                    clear_max_en,
  output logic [TOTAL_WIDTH-1:0]  snap_sts,
  output logic [SEQ_WIDTH-1:0]    snap_seq,
  output logic                    snap_valid,
  output logic                    max_clear,
  output logic                    busy,
  output logic                    overrun
);

  localparam int CW = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LOAD =
    CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          pending;
  logic          toggle_q;
  logic          auto_tick;
  logic          req;

  sts_period_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .aclk        (aclk),
    .areset      (areset),
    .auto_period (auto_period),
    .tick        (auto_tick)
  );

  // Toggle history tracks the input even in reset, so a level held across
  // reset release is not mistaken for a request.
  always_ff @(posedge aclk) begin
    toggle_q <= snap_toggle;
  end

  // Manual and auto requests collapse into a single request.
  assign req = (snap_toggle ^ toggle_q) | auto_tick;

  // Sequencer FSM with registered outputs and one-deep request queue.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      max_clear  <= 1'b0;
      snap_sts   <= '0;
      snap_seq   <= '0;
    end else begin
      snap_valid <= 1'b0;
      max_clear  <= 1'b0;
      case (state)
        IDLE: begin
          if (req || pending) begin
            busy    <= 1'b1;
            // Taking a pending request while a fresh one arrives leaves the
            // fresh one queued.
            pending <= pending & req;
            if (SETTLE_CYCLES == 0) begin
              state <= CAPTURE;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (req) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
          if (settle_cnt == '0) state <= CAPTURE;
          else                  settle_cnt <= settle_cnt - CW'(1);
        end
        CAPTURE: begin
          if (req) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
          snap_sts   <= live_sts;
          snap_seq   <= snap_seq + SEQ_WIDTH'(1);
          snap_valid <= 1'b1;
          max_clear  <= clear_max_en;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sts_snapshot_ctrl.md
# sts_snapshot_ctrl

Snapshot sequencer for the packed status vector read by the PS over AXI. It freezes a coherent copy of the live status bus on request, so multi-word fields such as the 64-bit sample and trigger timestamps are never read torn. Requests come from a PS-written toggle bit or from an internal periodic timer. On each capture it can also issue a clear pulse to the ADC abs-max tracker. It sits between the status packer output and the AXI status register slice.

## Interface
- TOTAL_WIDTH, 160, width of live and frozen status vectors
- SETTLE_CYCLES, 4, cycles waited between request and capture (0 allowed)
- PERIOD_WIDTH, 32, width of auto-snapshot period input
- SEQ_WIDTH, 16, width of snapshot sequence counter

Ports:
- aclk  in  1  system clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- live_sts  in  TOTAL_WIDTH  packed live status vector
- snap_toggle  in  1  PS config bit; every change of level is one manual request
- auto_period  in  PERIOD_WIDTH  auto-request period in cycles; 0 disables auto mode
- clear_max_en  in  1  when 1, each capture also pulses max_clear
- snap_sts  out  TOTAL_WIDTH  frozen status copy
- snap_seq  out  SEQ_WIDTH  count of completed captures, wraps
- snap_valid  out  1  one-cycle pulse, aligned with new snap_sts/snap_seq
- max_clear  out  1  one-cycle pulse to the abs-max tracker
- busy  out  1  high while a snapshot is in progress
- overrun  out  1  sticky: a request was dropped

## Operation
- Manual request: snap_toggle differs from registered copy toggle_q. toggle_q loads snap_toggle every cycle, including during reset, so a level present at reset release is not a request.
- Auto request: period counter counts 0..auto_period-1 and fires at the terminal count. auto_period==0 holds the counter at 0 with no requests. A change of auto_period restarts the counter at 0.
- Manual and auto requests in the same cycle merge into one request. This does not count as an overrun.
- FSM states:
  - IDLE: a request or pending flag moves to SETTLE, or to CAPTURE when SETTLE_CYCLES==0. Pending is cleared when taken.
  - SETTLE: a down-counter loaded with SETTLE_CYCLES-1 runs; moves to CAPTURE when it reaches 0.
  - CAPTURE: one cycle. snap_sts loads live_sts, snap_seq increments, snap_valid is registered high, and max_clear is registered high if clear_max_en. Returns to IDLE.
- Request while in SETTLE or CAPTURE: sets one-deep pending. If pending is already set, the request is dropped and overrun is set.
- overrun is cleared only by areset.
- snap_seq wraps from 2^SEQ_WIDTH-1 to 0.
- Reset values:
  - state IDLE
  - snap_sts, snap_seq 0
  - snap_valid, max_clear, busy, overrun, pending 0
  - period counter 0

## Timing
- Request detected in cycle N leads to:
  - busy high from N+1
  - CAPTURE state in cycle N+1+SETTLE_CYCLES
  - snap_sts, snap_seq, snap_valid and max_clear updated or pulsed in cycle N+2+SETTLE_CYCLES
  - busy low in that same cycle
- The captured value is live_sts at the clock edge ending the CAPTURE cycle.
- Pending request: IDLE for exactly one cycle after CAPTURE, then SETTLE (or CAPTURE).
- areset mid-snapshot: abort with no snap_valid and no max_clear. snap_sts returns to 0.
- Throughput: one snapshot per SETTLE_CYCLES+2 cycles maximum.

## Structure
- Package sts_ctrl_pkg holds:
  - state enum (IDLE, SETTLE, CAPTURE)
  - default parameter constants
- Sub-module sts_period_timer holds the auto-request counter:
  - inputs aclk, areset, auto_period
  - output one-cycle tick
  - restarts on period change

## Test plan
- Reset release with snap_toggle=1, no activity for 20 cycles -> snap_valid never asserted, snap_seq=0, overrun=0.
- SETTLE_CYCLES=4, live_sts=0xA5, toggle snap_toggle at cycle 10 -> busy at 11, snap_valid at 16 with snap_sts=0xA5, snap_seq=1; max_clear pulse at 16 iff clear_max_en=1.
- auto_period=100, snap_toggle static for 1000 cycles -> 10 snapshots spaced exactly 100 cycles apart; snap_seq 1..10.
- Toggle at cycles 10, 12, 13 with SETTLE_CYCLES=4 -> two captures, at 16 and 22; overrun=1 after cycle 13.
- Manual and auto request in same cycle -> one capture, overrun stays 0; SETTLE_CYCLES=0 gives snap_valid at N+2.
- areset asserted in SETTLE -> no snap_valid or max_clear, all outputs return to 0; snap_seq=0xFFFF then a capture -> 0.
